normalize_and_round: RTL and testbench

//  Post-add/sub stage of the FP adder/subtractor datapath. Pre-add alignment right-shifts mantissas;

---
 rtl/normalize_and_round.sv | 177 +++++++++++++++++
 tb/tb_normalize_and_round.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_and_round.sv
// normalize_and_round
//   Post-add/sub stage of the FP adder/subtractor. It takes the raw mantissa sum
//   {carry, hidden, fraction} plus guard/round/sticky, normalises it and rounds it.
//   It emits a packed IEEE-754 result with status flags.
//   - Carry-out: a single right shift.
//   - Otherwise: left shifts, one bit per cycle, until the hidden bit is set or
//     the exponent reaches 1.
//   One operation is in flight at a time; valid/ready handshakes on both sides.
//
//   Build option: FP_ROUND_NEAREST_EN
//     defined   -> round-to-nearest-even
//     undefined -> truncate; grs only feeds out_inexact
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake; in_ready is high only while idle
//   in_sign, in_exp    result sign, biased exponent of the aligned operands
//   in_man             raw sum: [MAN_W+1] carry, [MAN_W] hidden, rest fraction
//   in_grs             guard, round, sticky from alignment
//   out_valid/out_ready  output handshake; result held until accepted
//   out_result         {sign, exp field, fraction}
//   out_ovf            overflow, result is +/-inf
//   out_uf             subnormal result
//   out_inexact        discarded bits were nonzero
module normalize_and_round #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_W-1:0]       in_exp,
   input  logic [MAN_W+1:0]       in_man,
   input  logic [2:0]             in_grs,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic                   out_ovf,
   output logic                   out_uf,
   output logic                   out_inexact
);

   localparam int MW = MAN_W + 2;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t            state;
   logic              sign_q;
   logic              zero_q;
   logic              ovf_q;
   logic [EXP_W-1:0]  exp_q;
   logic [MW-1:0]     man_q;
   logic [2:0]        grs_q;

   // Rounding datapath, consumed in ROUND
   logic              round_up;
   logic [MW-1:0]     man_sum;
   logic [MW-1:0]     man_rnd;
   logic [EXP_W-1:0]  exp_rnd;
   logic              ovf_rnd;
   logic [EXP_W-1:0]  field;
   logic [MAN_W-1:0]  frac;

   assign in_ready = (state == IDLE);

   always_comb begin
`ifdef FP_ROUND_NEAREST_EN
      round_up = grs_q[2] & (grs_q[1] | grs_q[0] | man_q[0]);
`else
      round_up = 1'b0;
`endif
      man_sum = man_q + {{(MW-1){1'b0}}, round_up};
      man_rnd = man_sum;
      exp_rnd = exp_q;
      ovf_rnd = ovf_q;
      // Increment rippled past the hidden bit: renormalise to 1.000...
      if (man_sum[MW-1]) begin
         man_rnd = {2'b01, {MAN_W{1'b0}}};
         exp_rnd = exp_q + 1'b1;
         if (exp_q + 1'b1 == EXP_ONES) ovf_rnd = 1'b1;
      end
      // No hidden bit means subnormal encoding; a subnormal that rounded up
      // into the hidden bit leaves NORM with exp 1, so it encodes as field 1.
      field = man_rnd[MAN_W] ? exp_rnd : '0;
      frac  = man_rnd[MAN_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         exp_q       <= '0;
         man_q       <= '0;
         grs_q       <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_ovf     <= 1'b0;
         out_uf      <= 1'b0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q <= in_sign;
                  exp_q  <= in_exp;
                  man_q  <= in_man;
                  grs_q  <= in_grs;
                  zero_q <= 1'b0;
                  ovf_q  <= 1'b0;
                  if (in_man == '0 && in_grs == 3'b000) begin
                     zero_q <= 1'b1;
                     sign_q <= 1'b0;
                     state  <= ROUND;
                  end else if (in_man[MW-1]) begin
                     // Carry-out: the shifted-out LSB becomes guard, and the
                     // old round and sticky bits fold into sticky.
                     man_q <= in_man >> 1;
                     grs_q <= {in_man[0], in_grs[2], in_grs[1] | in_grs[0]};
                     exp_q <= in_exp + 1'b1;
                     ovf_q <= (in_exp == EXP_ONES) || (in_exp == EXP_ONES - 1'b1);
                     state <= ROUND;
                  end else if (in_exp == EXP_ONES) begin
                     ovf_q <= 1'b1;
                     state <= ROUND;
                  end else begin
                     // Exponent 0 normalises as 1 (subnormal floor)
                     if (in_exp == '0) exp_q <= EXP_ONE;
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (man_q[MAN_W] || exp_q <= EXP_ONE) begin
                  state <= ROUND;
               end else begin
                  // Shift in guard; sticky replicates into the vacated slot
                  man_q <= {man_q[MW-2:0], grs_q[2]};
                  grs_q <= {grs_q[1], grs_q[0], grs_q[0]};
                  exp_q <= exp_q - 1'b1;
               end
            end
            ROUND: begin
               out_inexact <= |grs_q;
               out_valid   <= 1'b1;
               state       <= DONE;
               if (zero_q) begin
                  out_result <= '0;
                  out_ovf    <= 1'b0;
                  out_uf     <= 1'b0;
               end else if (ovf_rnd) begin
                  out_result <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                  out_ovf    <= 1'b1;
                  out_uf     <= 1'b0;
               end else begin
                  out_result <= {sign_q, field, frac};
                  out_ovf    <= 1'b0;
                  out_uf     <= (field == '0) && (frac != '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_normalize_and_round.sv
module tb_normalize_and_round;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [24:0] in_man = '0;
   logic [2:0]  in_grs = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_uf;
   logic        out_inexact;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   normalize_and_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_grs(in_grs),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_ovf(out_ovf), .out_uf(out_uf),
      .out_inexact(out_inexact)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the sum plus its grs bits form one bit string in which the
   // sticky bit repeats forever. Normalising is a left shift of that string by
   // the leading-zero count, capped so the exponent never drops below 1.
   function automatic void model(input logic s, input logic [7:0] e_in,
                                 input logic [24:0] m_in, input logic [2:0] grs,
                                 output logic [31:0] res, output logic ovf,
                                 output logic uf, output logic inx, output int lat);
      logic [63:0] ext;
      logic [24:0] m;
      logic        g, r, st, ru;
      int          e, k, p;
      longint      mm;
      logic [7:0]  fld;
      ovf = 1'b0; uf = 1'b0;
      if (m_in == 0 && grs == 0) begin
         res = 32'h0; inx = 1'b0; lat = 1;
         return;
      end
      if (m_in[24]) begin
         m = m_in >> 1; g = m_in[0]; r = grs[2]; st = grs[1] | grs[0];
         e = int'(e_in) + 1; lat = 1;
      end else if (e_in == 8'hFF) begin
         m = m_in; g = grs[2]; r = grs[1]; st = grs[0]; e = 255; lat = 1;
      end else begin
         e = (e_in == 0) ? 1 : int'(e_in);
         ext = {m_in, grs[2], grs[1], {37{grs[0]}}};
         p = 0;
         for (int i = 62; i >= 0; i--) if (ext[i]) begin p = i; break; end
         k = 62 - p;
         if (k > e - 1) k = e - 1;
         ext = ext << k;
         if (grs[0]) ext = ext | ((64'd1 << k) - 64'd1);
         m = ext[63:39]; g = ext[38]; r = ext[37]; st = ext[36];
         e = e - k; lat = k + 2;
      end
      inx = g | r | st;
`ifdef FP_ROUND_NEAREST_EN
      ru = g & (r | st | m[0]);
`else
      ru = 1'b0;
`endif
      mm = longint'(m) + longint'(ru);
      if (mm == (longint'(1) << 24)) begin
         mm = longint'(1) << 23;
         e = e + 1;
      end
      if (e >= 255) begin
         res = {s, 8'hFF, 23'h0}; ovf = 1'b1;
      end else begin
         fld = mm[23] ? 8'(e) : 8'h0;
         res = {s, fld, mm[22:0]};
         uf = (fld == 0) && (mm[22:0] != 0);
      end
   endfunction

   task automatic start_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                           input logic [2:0] grs);
      @(negedge clk);
      chk("in_ready_before_accept", in_ready, 1'b1);
      in_sign = s; in_exp = e; in_man = m; in_grs = grs; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk); lat++;
         @(negedge clk);
      end while (!out_valid && lat < 200);
      chk("out_valid_within_bound", out_valid, 1'b1);
   endtask

   task automatic check_out(input string tag, input logic [31:0] res, input logic ovf,
                            input logic uf, input logic inx, input int lat_exp,
                            input int lat_obs);
      chk({tag, "_result"}, out_result, res);
      chk({tag, "_ovf"}, out_ovf, ovf);
      chk({tag, "_uf"}, out_uf, uf);
      chk({tag, "_inexact"}, out_inexact, inx);
      chk({tag, "_latency"}, 64'(lat_obs), 64'(lat_exp));
      chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("out_valid_dropped", out_valid, 1'b0);
      chk("in_ready_restored", in_ready, 1'b1);
   endtask

   task automatic run_directed(input string tag, input logic s, input logic [7:0] e,
                               input logic [24:0] m, input logic [2:0] grs,
                               input logic [31:0] res, input logic ovf, input logic uf,
                               input logic inx, input int lat_exp);
      int lat;
      start_op(s, e, m, grs);
      wait_out(lat);
      check_out(tag, res, ovf, uf, inx, lat_exp, lat);
      release_out();
   endtask

   initial begin
      int lat, mlat;
      logic [31:0] mres;
      logic movf, muf, minx;
      logic [7:0] re;
      logic [24:0] rm;
      logic [2:0] rg;
      logic rs;

      // Reset state
      #12;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_result", out_result, 32'h0);
      chk("reset_flags", {out_ovf, out_uf, out_inexact}, 3'b000);
      @(negedge clk); rst_n = 1'b1;

      // Directed cases
      run_directed("carry", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 0, 0, 0, 1);
      run_directed("one_shift", 1'b0, 8'd127, 25'h0400000, 3'b000, 32'h3F000000, 0, 0, 0, 3);
`ifdef FP_ROUND_NEAREST_EN
      run_directed("round_carry", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 0, 0, 1, 2);
`else
      run_directed("truncate", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h3FFFFFFF, 0, 0, 1, 2);
`endif
      run_directed("overflow", 1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 1, 0, 0, 1);
      run_directed("subnormal", 1'b0, 8'd3, 25'h0000001, 3'b000, 32'h00000004, 0, 1, 0, 4);
      run_directed("zero", 1'b1, 8'd50, 25'h0, 3'b000, 32'h00000000, 0, 0, 0, 1);
      run_directed("exp_ones", 1'b1, 8'hFF, 25'h0800000, 3'b000, 32'hFF800000, 1, 0, 0, 1);

      // Backpressure: result and flags hold, no new input accepted
      start_op(1'b0, 8'd127, 25'h1000000, 3'b000);
      wait_out(lat);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_result", out_result, 32'h40000000);
         chk("bp_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      release_out();

      // Reset while normalising a new op aborts it
      start_op(1'b0, 8'd100, 25'h0000001, 3'b000);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_out_valid", out_valid, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", in_ready, 1'b1);
      repeat (30) @(negedge clk);
      chk("post_reset_no_stale_out", out_valid, 1'b0);
      run_directed("after_reset", 1'b1, 8'd127, 25'h0400000, 3'b000, 32'hBF000000, 0, 0, 0, 3);

      // Randomized against the reference model
      for (int n = 0; n < 60; n++) begin
         rs = 1'($urandom);
         case ($urandom_range(0, 9))
            0: re = 8'd0;
            1: re = 8'hFF;
            2: re = 8'hFE;
            3: re = 8'(1 + $urandom_range(0, 4));
            default: re = 8'($urandom_range(1, 253));
         endcase
         rm = 25'($urandom) >> $urandom_range(0, 25);
         rg = 3'($urandom);
         model(rs, re, rm, rg, mres, movf, muf, minx, mlat);
         start_op(rs, re, rm, rg);
         wait_out(lat);
         check_out("rand", mres, movf, muf, minx, mlat, lat);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("rand_hold_result", out_result, mres);
         end
         release_out();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
